// File: rtl/wb_resp_pkg.sv
// Shared types and helpers for the Wishbone memory responder.
//   resp_t   : one response slot (valid, err, irq, read data)
//   LFSR_TAPS: feedback mask for the 16-bit Fibonacci LFSR (x^16 + x^14 + x^13 + x^11 + 1)
//   classify : decides ack/err/irq for a request at accept time
package wb_resp_pkg;

    typedef struct packed {
        logic        valid;
        logic        err;
        logic        irq;
        logic [31:0] data;
    } resp_t;

    // Bits 15, 13, 12, 10 of the state correspond to taps 16, 14, 13, 11.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Returns a valid response slot with err/irq resolved; data is filled by the caller.
    // Forced error wins over everything, then the doorbell, then the RAM range check.
    function automatic resp_t classify(
        input logic [31:0] addr,
        input logic        we,
        input logic        force_err,
        input logic [31:0] depth,
        input logic [31:0] doorbell
    );
        resp_t r;
        r       = '0;
        r.valid = 1'b1;
        if (force_err) begin
            r.err = 1'b1;
        end else if (addr == doorbell) begin
            r.irq = we;
        end else if (addr >= depth) begin
            r.err = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR, shifts left every cycle, reloads SEED on reset.
//   i_clk   : clock
//   i_rst_n : asynchronous active-low reset
//   o_state : current LFSR state
module lfsr16
    import wb_resp_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic [15:0] o_state
);

    logic [15:0] state_q, state_d;

    always_comb begin
        state_d = {state_q[14:0], ^(state_q & LFSR_TAPS)};
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign o_state = state_q;

endmodule

// File: rtl/wb_mem_responder.sv
// Pipelined Wishbone B4 responder backed by a word RAM, with fixed response latency,
// random/forced stalls, error injection and a doorbell interrupt.
//   i_clk, i_rst_n         : clock, asynchronous active-low reset
//   i_wb_cyc/stb/we        : bus cycle, request strobe, write enable
//   i_wb_addr, i_wb_data   : word address, write data
//   o_wb_ack, o_wb_err     : success / error response (exactly one per accepted request)
//   o_wb_stall             : request not accepted this cycle
//   o_wb_data              : read data, zero unless acking a read
//   i_force_stall          : forces stall
//   i_force_error          : the request accepted this cycle will respond with err
//   o_irq                  : one-cycle pulse alongside the ack of a doorbell write
module wb_mem_responder
    import wb_resp_pkg::*;
#(
    parameter int unsigned DEPTH         = 128,
    parameter int unsigned LATENCY       = 2,
    parameter int unsigned STALL_EN      = 1,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1,
    parameter logic [31:0] DOORBELL_ADDR = 32'hFFFF_0000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic        i_wb_we,
    input  logic [31:0] i_wb_addr,
    input  logic [31:0] i_wb_data,
    output logic        o_wb_ack,
    output logic        o_wb_err,
    output logic        o_wb_stall,
    output logic [31:0] o_wb_data,
    input  logic        i_force_stall,
    input  logic        i_force_error,
    output logic        o_irq
);

    localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

    logic [15:0]   lfsr;
    logic          stall;
    logic          accept;
    logic          ram_hit;
    logic          ram_we;
    logic [AW-1:0] ram_idx;
    logic [31:0]   ram_q [DEPTH];
    resp_t         req;
    resp_t         head;

    // acc_q captures the classified request and its RAM read at the accept edge; the pipe
    // then delays it by LATENCY more edges so the response appears after edge N+LATENCY.
    resp_t acc_d, acc_q;
    resp_t pipe_d [LATENCY];
    resp_t pipe_q [LATENCY];

    logic unused_lfsr;
    assign unused_lfsr = ^lfsr[15:2];

    lfsr16 #(
        .SEED(LFSR_SEED)
    ) u_lfsr (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .o_state(lfsr)
    );

    always_comb begin
        stall   = i_force_stall | ((STALL_EN != 0) & lfsr[0] & lfsr[1]);
        accept  = i_wb_cyc & i_wb_stb & ~stall;
        ram_idx = i_wb_addr[AW-1:0];
        req     = classify(i_wb_addr, i_wb_we, i_force_error, DEPTH_W, DOORBELL_ADDR);
        // Not an error and not the doorbell means an in-range RAM access.
        ram_hit = accept & ~req.err & (i_wb_addr != DOORBELL_ADDR);
        ram_we  = ram_hit & i_wb_we;

        acc_d = '0;
        if (accept) begin
            acc_d = req;
            if (ram_hit && !i_wb_we) begin
                acc_d.data = ram_q[ram_idx];
            end
        end

        pipe_d[0] = acc_q;
        for (int i = 1; i < LATENCY; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
        // Cycle abort squashes everything in flight; committed writes stay.
        if (!i_wb_cyc) begin
            for (int i = 0; i < LATENCY; i++) begin
                pipe_d[i] = '0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            acc_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            acc_q <= acc_d;
            for (int i = 0; i < LATENCY; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    // RAM contents survive reset.
    always_ff @(posedge i_clk) begin
        if (ram_we) begin
            ram_q[ram_idx] <= i_wb_data;
        end
    end

    always_comb begin
        head       = pipe_q[LATENCY-1];
        // Gating with cyc hides a response due in the same cycle the master aborts.
        o_wb_ack   = i_wb_cyc & head.valid & ~head.err;
        o_wb_err   = i_wb_cyc & head.valid & head.err;
        o_irq      = o_wb_ack & head.irq;
        o_wb_data  = o_wb_ack ? head.data : 32'h0;
        o_wb_stall = stall;
    end

endmodule

// File: tb/tb_wb_mem_responder.sv
module tb_wb_mem_responder;

    localparam int          LAT_A = 2;
    localparam int          LAT_B = 3;
    localparam logic [31:0] DB    = 32'hFFFF_0000;

    typedef struct {
        logic        err;
        logic        irq;
        logic        rd;
        logic [31:0] data;
        int          due;
    } exp_t;

    logic        clk, rst_n, sel;
    logic        cyc_a, cyc_b, stb, we, force_stall, force_error;
    logic [31:0] addr, wdata;
    logic        ack_a, err_a, stall_a, irq_a;
    logic        ack_b, err_b, stall_b, irq_b;
    logic [31:0] data_a, data_b;

    int          checks, errors, cyc_cnt;
    int          n_ack, n_err, n_irq, n_acc, last_resp_cycle, last_acc_edge;
    logic        last_accept, last_stall;
    logic [31:0] last_rdata;
    exp_t        sb_q[$];
    int          ack_cycles[$];
    logic [31:0] rdata_q[$];
    logic [31:0] model_mem [2][128];

    wb_mem_responder #(
        .DEPTH(128), .LATENCY(LAT_A), .STALL_EN(0), .LFSR_SEED(16'hACE1), .DOORBELL_ADDR(DB)
    ) u_dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_wb_cyc(cyc_a), .i_wb_stb(stb), .i_wb_we(we),
        .i_wb_addr(addr), .i_wb_data(wdata), .o_wb_ack(ack_a), .o_wb_err(err_a),
        .o_wb_stall(stall_a), .o_wb_data(data_a), .i_force_stall(force_stall),
        .i_force_error(force_error), .o_irq(irq_a)
    );

    wb_mem_responder #(
        .DEPTH(128), .LATENCY(LAT_B), .STALL_EN(1), .LFSR_SEED(16'hACE1), .DOORBELL_ADDR(DB)
    ) u_dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_wb_cyc(cyc_b), .i_wb_stb(stb), .i_wb_we(we),
        .i_wb_addr(addr), .i_wb_data(wdata), .o_wb_ack(ack_b), .o_wb_err(err_b),
        .o_wb_stall(stall_b), .o_wb_data(data_b), .i_force_stall(force_stall),
        .i_force_error(force_error), .o_irq(irq_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: time limit reached, summary not printed");
        $fatal(1, "watchdog");
    end

    // Scoreboard: runs at the negedge before each active edge.
    task automatic sb_sample();
        logic        s_ack, s_err, s_irq, s_stall, s_cyc;
        logic [31:0] s_data;
        exp_t        e;
        int          lat;
        s_ack   = sel ? ack_b : ack_a;
        s_err   = sel ? err_b : err_a;
        s_irq   = sel ? irq_b : irq_a;
        s_stall = sel ? stall_b : stall_a;
        s_data  = sel ? data_b : data_a;
        s_cyc   = sel ? cyc_b : cyc_a;
        lat     = sel ? LAT_B : LAT_A;
        last_accept = 1'b0;
        last_stall  = s_stall;
        if (!rst_n) begin
            sb_q.delete();
        end else if (!s_cyc) begin
            checks++;
            if (s_ack || s_err || s_irq || s_data !== 32'h0) begin
                errors++;
                $display("FAIL idle_bus @%0d: ack=%0b err=%0b irq=%0b data=%h, want all zero",
                         cyc_cnt, s_ack, s_err, s_irq, s_data);
            end
            sb_q.delete();
        end else begin
            if (s_ack || s_err) begin
                if (s_ack) n_ack++;
                if (s_err) n_err++;
                if (s_irq) n_irq++;
                ack_cycles.push_back(cyc_cnt);
                last_resp_cycle = cyc_cnt;
                if (s_ack) last_rdata = s_data;
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL spurious_resp @%0d: ack=%0b err=%0b, want no response",
                             cyc_cnt, s_ack, s_err);
                end else begin
                    e = sb_q.pop_front();
                    if (s_ack && e.rd) rdata_q.push_back(s_data);
                    if (s_ack !== !e.err || s_err !== e.err || s_irq !== e.irq ||
                        s_data !== e.data || cyc_cnt != e.due) begin
                        errors++;
                        $display("FAIL resp: got ack=%0b err=%0b irq=%0b data=%h cycle=%0d, want ack=%0b err=%0b irq=%0b data=%h cycle=%0d",
                                 s_ack, s_err, s_irq, s_data, cyc_cnt,
                                 !e.err, e.err, e.irq, e.data, e.due);
                    end
                end
            end else begin
                if (s_irq) n_irq++;
                checks++;
                if (s_irq || s_data !== 32'h0) begin
                    errors++;
                    $display("FAIL stray_out @%0d: irq=%0b data=%h without response, want 0/0",
                             cyc_cnt, s_irq, s_data);
                end
                if (sb_q.size() != 0 && sb_q[0].due <= cyc_cnt) begin
                    checks++;
                    errors++;
                    $display("FAIL missing_resp @%0d: no ack/err, want response due at %0d",
                             cyc_cnt, sb_q[0].due);
                    void'(sb_q.pop_front());
                end
            end
            if (stb && !s_stall) begin
                e.due  = cyc_cnt + 1 + lat;
                e.err  = 1'b0;
                e.irq  = 1'b0;
                e.rd   = 1'b0;
                e.data = 32'h0;
                if (force_error) begin
                    e.err = 1'b1;
                end else if (addr == DB) begin
                    e.irq = we;
                end else if (addr < 32'd128) begin
                    if (we) begin
                        model_mem[sel][addr[6:0]] = wdata;
                    end else begin
                        e.data = model_mem[sel][addr[6:0]];
                        e.rd   = 1'b1;
                    end
                end else begin
                    e.err = 1'b1;
                end
                sb_q.push_back(e);
                n_acc++;
                last_accept   = 1'b1;
                last_acc_edge = cyc_cnt + 1;
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        sb_sample();
        @(posedge clk);
        cyc_cnt++;
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle();
    endtask

    // Single request, held until accepted (bounded), then strobe dropped with cyc still high.
    task automatic do_op(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic fe);
        int n;
        n = 0;
        if (sel) cyc_b = 1'b1; else cyc_a = 1'b1;
        stb = 1'b1; we = w; addr = a; wdata = d; force_error = fe;
        do begin
            cycle();
            n++;
        end while (!last_accept && n < 200);
        checks++;
        if (!last_accept) begin
            errors++;
            $display("FAIL accept_timeout: addr=%h not accepted in %0d cycles, want accept", a, n);
        end
        stb = 1'b0; we = 1'b0; force_error = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({ack_a, err_a, stall_a, irq_a} !== 4'b0 || data_a !== 32'h0) begin
            errors++;
            $display("FAIL reset_a: ack/err/stall/irq=%b data=%h, want 0000/0",
                     {ack_a, err_a, stall_a, irq_a}, data_a);
        end
        checks++;
        if ({ack_b, err_b, stall_b, irq_b} !== 4'b0 || data_b !== 32'h0) begin
            errors++;
            $display("FAIL reset_b: ack/err/stall/irq=%b data=%h, want 0000/0",
                     {ack_b, err_b, stall_b, irq_b}, data_b);
        end
        idle(3);
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_write_read();
        int a0;
        a0 = n_ack;
        do_op(1'b1, 32'd5, 32'hDEAD_BEEF, 1'b0);
        idle(4);
        do_op(1'b0, 32'd5, 32'h0, 1'b0);
        idle(4);
        checks++;
        if (n_ack - a0 != 2) begin
            errors++;
            $display("FAIL wr_rd_acks: got %0d acks, want 2", n_ack - a0);
        end
        checks++;
        if (last_resp_cycle - last_acc_edge != LAT_A) begin
            errors++;
            $display("FAIL wr_rd_latency: got %0d, want %0d", last_resp_cycle - last_acc_edge, LAT_A);
        end
        checks++;
        if (last_rdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL wr_rd_data: got %h, want deadbeef", last_rdata);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) do_op(1'b1, i, 32'h1000_0000 + i, 1'b0);
        idle(4);
        ack_cycles.delete();
        rdata_q.delete();
        cyc_a = 1'b1; stb = 1'b1; we = 1'b0;
        for (int i = 0; i < 8; i++) begin
            addr = i;
            cycle();
            checks++;
            if (!last_accept) begin
                errors++;
                $display("FAIL b2b_accept: read %0d accepted=0, want 1", i);
            end
        end
        stb = 1'b0;
        idle(5);
        checks++;
        if (ack_cycles.size() != 8) begin
            errors++;
            $display("FAIL b2b_count: got %0d responses, want 8", ack_cycles.size());
        end else begin
            checks++;
            if (ack_cycles[7] - ack_cycles[0] != 7) begin
                errors++;
                $display("FAIL b2b_gaps: span %0d cycles, want 7", ack_cycles[7] - ack_cycles[0]);
            end
        end
        for (int i = 0; i < 8 && i < rdata_q.size(); i++) begin
            checks++;
            if (rdata_q[i] !== 32'h1000_0000 + i) begin
                errors++;
                $display("FAIL b2b_data[%0d]: got %h, want %h", i, rdata_q[i], 32'h1000_0000 + i);
            end
        end
    endtask

    task automatic test_errors();
        int a0, e0;
        a0 = n_ack; e0 = n_err;
        do_op(1'b0, 32'd128, 32'h0, 1'b0);
        idle(4);
        checks++;
        if (n_err - e0 != 1 || n_ack - a0 != 0) begin
            errors++;
            $display("FAIL oob_read: got err=%0d ack=%0d, want err=1 ack=0", n_err - e0, n_ack - a0);
        end
        e0 = n_err;
        do_op(1'b1, 32'd3, 32'h5555_5555, 1'b1);
        idle(4);
        checks++;
        if (n_err - e0 != 1) begin
            errors++;
            $display("FAIL forced_err: got %0d errs, want 1", n_err - e0);
        end
        do_op(1'b0, 32'd3, 32'h0, 1'b0);
        idle(4);
        checks++;
        if (last_rdata !== 32'h1000_0003) begin
            errors++;
            $display("FAIL forced_err_nowrite: got %h, want 10000003", last_rdata);
        end
    endtask

    task automatic test_doorbell();
        int i0, a0;
        i0 = n_irq; a0 = n_ack;
        do_op(1'b1, DB, 32'h1234_5678, 1'b0);
        idle(4);
        checks++;
        if (n_irq - i0 != 1 || n_ack - a0 != 1) begin
            errors++;
            $display("FAIL db_write: got irq_cycles=%0d acks=%0d, want 1/1", n_irq - i0, n_ack - a0);
        end
        last_rdata = 32'hFFFF_FFFF;
        do_op(1'b0, DB, 32'h0, 1'b0);
        idle(4);
        checks++;
        if (n_irq - i0 != 1 || n_ack - a0 != 2 || last_rdata !== 32'h0) begin
            errors++;
            $display("FAIL db_read: got irq_cycles=%0d acks=%0d data=%h, want 1/2/0",
                     n_irq - i0, n_ack - a0, last_rdata);
        end
    endtask

    task automatic test_force_stall();
        int acc0, a0, st;
        acc0 = n_acc; a0 = n_ack; st = 0;
        cyc_a = 1'b1; stb = 1'b1; we = 1'b0; addr = 32'd1; force_stall = 1'b1;
        repeat (10) begin
            cycle();
            if (last_stall) st++;
        end
        checks++;
        if (n_acc != acc0 || st != 10 || n_ack != a0) begin
            errors++;
            $display("FAIL force_stall: got accepts=%0d stall_cycles=%0d acks=%0d, want 0/10/0",
                     n_acc - acc0, st, n_ack - a0);
        end
        force_stall = 1'b0;
        cycle();
        checks++;
        if (!last_accept) begin
            errors++;
            $display("FAIL stall_release: accepted=0, want 1");
        end
        stb = 1'b0;
        idle(4);
        checks++;
        if (n_ack - a0 != 1) begin
            errors++;
            $display("FAIL stall_release_ack: got %0d acks, want 1", n_ack - a0);
        end
    endtask

    task automatic test_abort();
        int r0;
        r0 = n_ack + n_err;
        cyc_a = 1'b1; stb = 1'b1; we = 1'b1;
        for (int i = 0; i < 3; i++) begin
            addr = 32'd20 + i;
            wdata = 32'hA0 + i;
            cycle();
        end
        cyc_a = 1'b0; stb = 1'b0; we = 1'b0;
        cycle();
        cyc_a = 1'b1;
        idle(5);
        checks++;
        if (n_ack + n_err != r0) begin
            errors++;
            $display("FAIL abort_resp: got %0d responses, want 0", n_ack + n_err - r0);
        end
        do_op(1'b0, 32'd20, 32'h0, 1'b0);
        idle(4);
        checks++;
        if (last_rdata !== 32'hA0) begin
            errors++;
            $display("FAIL abort_commit: got %h, want 000000a0", last_rdata);
        end
    endtask

    task automatic test_reset_mid_burst();
        int r0;
        cyc_a = 1'b1; stb = 1'b1; we = 1'b0;
        for (int i = 0; i < 4; i++) begin
            addr = i;
            cycle();
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ack_a, err_a, stall_a, irq_a} !== 4'b0 || data_a !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid: ack/err/stall/irq=%b data=%h, want 0000/0",
                     {ack_a, err_a, stall_a, irq_a}, data_a);
        end
        stb = 1'b0;
        idle(2);
        rst_n = 1'b1;
        r0 = n_ack + n_err;
        idle(8);
        checks++;
        if (n_ack + n_err != r0) begin
            errors++;
            $display("FAIL rst_release: got %0d responses, want 0", n_ack + n_err - r0);
        end
    endtask

    task automatic test_random();
        int          n, r;
        logic        w, fe;
        logic [31:0] a;
        cyc_a = 1'b0;
        sel   = 1'b1;
        for (int i = 0; i < 128; i++) do_op(1'b1, i, $urandom(), 1'b0);
        idle(5);
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 32) == 0) begin
                cyc_b = 1'b0; stb = 1'b0;
                cycle();
                cyc_b = 1'b1;
            end
            if ($urandom_range(0, 4) == 0) begin
                stb = 1'b0;
                cycle();
            end
            r  = $urandom_range(0, 9);
            a  = (r <= 6) ? 32'($urandom_range(0, 127)) :
                 (r == 7) ? DB :
                 (r == 8) ? 32'($urandom_range(128, 400)) : $urandom();
            w  = 1'($urandom_range(0, 1));
            fe = ($urandom_range(0, 9) == 0);
            cyc_b = 1'b1; stb = 1'b1; we = w; addr = a; wdata = $urandom(); force_error = fe;
            n = 0;
            do begin
                force_stall = ($urandom_range(0, 9) == 0);
                cycle();
                n++;
            end while (!last_accept && n < 200);
            checks++;
            if (!last_accept) begin
                errors++;
                $display("FAIL rand_accept_timeout: op %0d not accepted, want accept", i);
            end
            stb = 1'b0; force_stall = 1'b0; force_error = 1'b0;
        end
        idle(10);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL rand_drain: %0d responses outstanding, want 0", sb_q.size());
        end
    endtask

    initial begin
        rst_n = 1'b0; sel = 1'b0;
        cyc_a = 1'b0; cyc_b = 1'b0; stb = 1'b0; we = 1'b0;
        force_stall = 1'b0; force_error = 1'b0;
        addr = 32'h0; wdata = 32'h0;
        checks = 0; errors = 0; cyc_cnt = 0;
        n_ack = 0; n_err = 0; n_irq = 0; n_acc = 0;
        last_resp_cycle = 0; last_acc_edge = 0;
        last_accept = 1'b0; last_stall = 1'b0; last_rdata = 32'h0;

        test_reset();
        test_write_read();
        test_back_to_back();
        test_errors();
        test_doorbell();
        test_force_stall();
        test_abort();
        test_reset_mid_burst();
        test_random();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
